// File: rtl/mmio_port_bank.sv
// mmio_port_bank: memory-mapped I/O slave with NUM_CH output channel
// registers, a free-running 32-bit cycle counter and a req/ack handshake
// with WAIT_STATES extra cycles before the one-cycle ack pulse.
// Optional feature: define MMIO_BYTE_STROBE_EN to add the wstrb input and
// byte-granular channel writes.
module mmio_port_bank #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
`ifdef MMIO_BYTE_STROBE_EN
    input  logic [DATA_W/8-1:0]      wstrb,
`endif
    output logic [DATA_W-1:0]        rdata,
    output logic                     ack,
    output logic                     err,
    output logic [NUM_CH*DATA_W-1:0] mem_map_io,
    output logic [31:0]              cycle_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The counter is loaded with WAIT_STATES-1 so WAIT lasts exactly
    // WAIT_STATES cycles (leaving on the cycle it reads zero).
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(NUM_CH);
    localparam int NUM_BYTES = DATA_W / 8;

    logic [1:0]        state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
`ifdef MMIO_BYTE_STROBE_EN
    logic [NUM_BYTES-1:0] wstrb_reg;
`endif
    logic [31:0]       cycle_count_reg;

    logic              accept;
    logic              in_resp;
    logic              is_ch;
    logic              is_cnt;
    logic              wr_fire;
    logic              cnt_clear;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] rd_word;

    assign accept    = (state_reg == ST_IDLE) && req;
    assign in_resp   = (state_reg == ST_RESP);
    assign is_ch     = (addr_reg < CNT_ADDR);
    assign is_cnt    = (addr_reg == CNT_ADDR);
    assign wr_fire   = in_resp && we_reg;
    assign cnt_clear = wr_fire && is_cnt;

    // Next-state logic for the IDLE -> (WAIT) -> RESP handshake.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
`ifdef MMIO_BYTE_STROBE_EN
            wstrb_reg <= '0;
`endif
        end else if (accept) begin
            we_reg    <= we;
            addr_reg  <= addr;
            wdata_reg <= wdata;
`ifdef MMIO_BYTE_STROBE_EN
            wstrb_reg <= wstrb;
`endif
        end
    end

    // Free-running counter; a clearing write overrides the increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_count_reg <= 32'd0;
        end else begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

    assign cycle_count = cycle_count_reg;

    // Per-byte write enables: all-ones unless byte strobes are built in.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_mask
`ifdef MMIO_BYTE_STROBE_EN
        assign wr_mask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
`else
        assign wr_mask[gi*8 +: 8] = 8'hFF;
`endif
    end

    // One register per channel, updated on the edge that ends RESP.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] ch_reg;

        // Merge selected bytes of the latched write data into the channel.
        always_ff @(posedge clk) begin
            if (rst) begin
                ch_reg <= '0;
            end else if (wr_fire && (addr_reg == ADDR_W'(gi))) begin
                ch_reg <= (ch_reg & ~wr_mask) | (wdata_reg & wr_mask);
            end
        end

        assign mem_map_io[gi*DATA_W +: DATA_W] = ch_reg;
    end

    // Read mux over the latched address: channels, then the counter.
    always_comb begin
        rd_word = '0;
        if (is_cnt) begin
            rd_word = DATA_W'(cycle_count_reg);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_reg == ADDR_W'(i)) begin
                rd_word = mem_map_io[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ack   = in_resp;
    assign err   = in_resp && !is_ch && !is_cnt;
    assign rdata = in_resp ? rd_word : '0;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Testbench for mmio_port_bank: two instances (0 and 3 wait states) are
// driven with directed and random accesses and compared against a
// behavioural model of channel contents and elapsed cycles.
module tb_mmio_port_bank;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int AW = 4;
    localparam int SW = DW / 8;
    localparam int FW = NC * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
`ifdef MMIO_BYTE_STROBE_EN
    logic [SW-1:0] wstrb [2];
`endif
    logic [DW-1:0] rdata [2];
    logic          ack   [2];
    logic          err   [2];
    logic [FW-1:0] io    [2];
    logic [31:0]   cnt   [2];

    mmio_port_bank #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]),
`ifdef MMIO_BYTE_STROBE_EN
        .wstrb(wstrb[0]),
`endif
        .rdata(rdata[0]), .ack(ack[0]), .err(err[0]),
        .mem_map_io(io[0]), .cycle_count(cnt[0])
    );

    mmio_port_bank #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]),
`ifdef MMIO_BYTE_STROBE_EN
        .wstrb(wstrb[1]),
`endif
        .rdata(rdata[1]), .ack(ack[1]), .err(err[1]),
        .mem_map_io(io[1]), .cycle_count(cnt[1])
    );

    // Reference model: channel contents plus the edge at which each
    // counter was last zeroed (by reset or a counter write).
    logic [DW-1:0] m_ch [2][NC];
    int unsigned   edges = 0;
    int unsigned   base    [2];
    int            clr_req [2];
    int            clr_seen[2];

    int checks   = 0;
    int failures = 0;

    // Count edges and note where each counter restarts from zero.
    always @(posedge clk) begin
        edges = edges + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst || (clr_req[d] != clr_seen[d])) begin
                base[d]     = edges;
                clr_seen[d] = clr_req[d];
            end
        end
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] mcount(input int d);
        return 32'(edges - base[d]);
    endfunction

    function automatic logic [FW-1:0] mflat(input int d);
        logic [FW-1:0] f;
        for (int i = 0; i < NC; i++) f[i*DW +: DW] = m_ch[d][i];
        return f;
    endfunction

    function automatic logic [DW-1:0] bmask(input logic [SW-1:0] st);
        logic [DW-1:0] m;
        m = '1;
`ifdef MMIO_BYTE_STROBE_EN
        for (int i = 0; i < SW; i++) m[i*8 +: 8] = {8{st[i]}};
`endif
        return m;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access; inputs are scrambled right after acceptance.
    task automatic access(input int d, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [SW-1:0] st);
        int k;
        bit got;
        bit in_ch;
        bit is_c;
        logic [DW-1:0] exp_rd;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
`ifdef MMIO_BYTE_STROBE_EN
        wstrb[d] = st;
`endif
        @(posedge clk);
        #1;
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = AW'($urandom); wdata[d] = $urandom;
`ifdef MMIO_BYTE_STROBE_EN
        wstrb[d] = SW'($urandom);
`endif
        k = 0;
        got = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (ack[d] === 1'b1) got = 1;
        end
        chk("ack_latency", FW'(k), FW'(ws_of(d) + 1));
        in_ch = (a < AW'(NC));
        is_c  = (a == AW'(NC));
        chk("err", FW'(err[d]), FW'(!(in_ch || is_c)));
        if (!w) begin
            exp_rd = in_ch ? m_ch[d][a] : (is_c ? mcount(d) : '0);
            chk("rdata", FW'(rdata[d]), FW'(exp_rd));
        end
        chk("count_at_resp", FW'(cnt[d]), FW'(mcount(d)));
        if (w && in_ch) m_ch[d][a] = (m_ch[d][a] & ~bmask(st)) | (wd & bmask(st));
        if (w && is_c) clr_req[d]++;
        @(negedge clk);
        chk("ack_single", FW'(ack[d]), FW'(0));
        chk("mem_map_io", io[d], mflat(d));
        chk("count_after", FW'(cnt[d]), FW'(mcount(d)));
    endtask

    // Hold reset for n edges, check the cleared state, then release.
    task automatic rst_pulse(input int n);
        @(negedge clk);
        rst = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (n) @(negedge clk);
        for (int d = 0; d < 2; d++) for (int i = 0; i < NC; i++) m_ch[d][i] = '0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_io", io[d], FW'(0));
            chk("rst_count", FW'(cnt[d]), FW'(mcount(d)));
            chk("rst_ack", FW'(ack[d]), FW'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("count_first", FW'(cnt[d]), FW'(1));
    endtask

    initial begin
        logic [DW-1:0] hd;
        bit any_ack;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; addr[d] = '0; wdata[d] = '0;
`ifdef MMIO_BYTE_STROBE_EN
            wstrb[d] = '0;
`endif
            clr_req[d] = 0; clr_seen[d] = 0; base[d] = 0;
            for (int i = 0; i < NC; i++) m_ch[d][i] = '0;
        end
        rst_pulse(2);

        // Basic write/read and error path with no wait states.
        access(0, 1, 4'd2, 32'hDEADBEEF, '1);
        chk("ch2_word", FW'(io[0][95:64]), FW'(32'hDEADBEEF));
        access(0, 0, 4'd2, 32'h0, '1);
        access(0, 1, 4'd9, 32'h1234, '1);
        access(0, 0, 4'd9, 32'h0, '1);

        // Counter read, then clear; it must restart from zero.
        access(0, 0, 4'd4, 32'h0, '1);
        access(0, 1, 4'd4, 32'hFFFF_FFFF, '1);
        @(negedge clk);
        chk("count_restart", FW'(cnt[0]), FW'(1));

        // Three wait states with req held high and inputs churning.
        @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            chk("held_ack", FW'(ack[1]), FW'(n % 5 == 4));
            req[1] = 1'b1;
`ifdef MMIO_BYTE_STROBE_EN
            wstrb[1] = '1;
`endif
            if (n % 5 == 0) begin
                hd = $urandom;
                we[1] = 1'b1; addr[1] = AW'(n / 5); wdata[1] = hd;
                m_ch[1][n / 5] = hd;
            end else begin
                we[1] = 1'($urandom); addr[1] = AW'($urandom); wdata[1] = $urandom;
            end
            @(negedge clk);
        end
        req[1] = 1'b0;
        @(negedge clk);
        chk("held_io", io[1], mflat(1));
        access(1, 0, 4'd3, 32'h0, '1);
        access(1, 0, 4'd4, 32'h0, '1);

`ifdef MMIO_BYTE_STROBE_EN
        access(0, 1, 4'd0, 32'hAABBCCDD, 4'b1111);
        access(0, 1, 4'd0, 32'h11223344, 4'b0101);
        chk("strobe_merge", FW'(io[0][31:0]), FW'(32'hAA22CC44));
        access(0, 1, 4'd0, 32'h55667788, 4'b0000);
        access(1, 1, 4'd4, 32'h0, 4'b0000);
`endif

        // Random traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 30; t++) begin
                access(d, 1'($urandom), AW'($urandom_range(0, 7)), $urandom, SW'($urandom));
            end
        end

        // Reset with registers populated, then reset in the middle of WAIT.
        access(1, 1, 4'd1, 32'h0BAD_F00D, '1);
        rst_pulse(2);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd1; wdata[1] = 32'hCAFE_0001;
`ifdef MMIO_BYTE_STROBE_EN
        wstrb[1] = '1;
`endif
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        any_ack = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack[1] !== 1'b0) any_ack = 1;
        end
        chk("rst_wait_no_ack", FW'(any_ack), FW'(0));
        chk("rst_wait_reg1", FW'(io[1][63:32]), FW'(0));
        chk("rst_wait_count", FW'(cnt[1]), FW'(mcount(1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
